// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter in front of a shared 32-bit sll/sra shifter.
// One operation is in flight at a time: accept -> EXEC -> RESP (held until res_ready).
module shift_arbiter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_in,
    input  logic [4:0]  req0_amt,
    input  logic        req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_in,
    input  logic [4:0]  req1_amt,
    input  logic        req1_op,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_id
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [31:0] op_in_q, op_in_d;
    logic [4:0]  op_amt_q, op_amt_d;
    logic        op_sel_q, op_sel_d;
    logic        op_id_q, op_id_d;
    logic [31:0] res_data_q, res_data_d;
    logic        res_id_q, res_id_d;

    // Requester ports gathered into indexable form.
    logic [1:0]  req_valid;
    logic [1:0]  req_ready_w;
    logic [31:0] req_in  [2];
    logic [4:0]  req_amt [2];
    logic [1:0]  req_op;

    assign req_valid  = {req1_valid, req0_valid};
    assign req_in[0]  = req0_in;
    assign req_in[1]  = req1_in;
    assign req_amt[0] = req0_amt;
    assign req_amt[1] = req1_amt;
    assign req_op     = {req1_op, req0_op};

    logic        grant_vld;
    logic        grant_id;
    logic        accept_window;
    logic        handshake;
    logic [31:0] shift_result;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (req_valid[0] && req_valid[1]) begin
            grant_vld = 1'b1;
            grant_id  = ~last_q;
        end else if (req_valid[0]) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
        end else if (req_valid[1]) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
        end
    end

    assign accept_window = (state_q == IDLE) || ((state_q == RESP) && res_ready);
    assign handshake     = accept_window && grant_vld;

    // Readies are forced low while reset is held, even though state reads IDLE then.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready_w[gi] = reset_n && handshake && (grant_id == 1'(gi));
        end
    endgenerate

    assign req0_ready = req_ready_w[0];
    assign req1_ready = req_ready_w[1];

    assign shift_result = op_sel_q ? 32'($signed(op_in_q) >>> op_amt_q)
                                   : (op_in_q << op_amt_q);

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        op_in_d    = op_in_q;
        op_amt_d   = op_amt_q;
        op_sel_d   = op_sel_q;
        op_id_d    = op_id_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;

        case (state_q)
            IDLE: begin
                if (handshake) state_d = EXEC;
            end
            EXEC: begin
                res_data_d = shift_result;
                res_id_d   = op_id_q;
                state_d    = RESP;
            end
            RESP: begin
                if (res_ready) state_d = handshake ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // handshake can only be true in IDLE or a releasing RESP.
        if (handshake) begin
            op_in_d  = req_in[grant_id];
            op_amt_d = req_amt[grant_id];
            op_sel_d = req_op[grant_id];
            op_id_d  = grant_id;
            last_d   = grant_id;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            op_in_q    <= '0;
            op_amt_q   <= '0;
            op_sel_q   <= 1'b0;
            op_id_q    <= 1'b0;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            op_in_q    <= op_in_d;
            op_amt_q   <= op_amt_d;
            op_sel_q   <= op_sel_d;
            op_id_q    <= op_id_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
        end
    end

    assign res_valid = (state_q == RESP);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of the arbiter and shifter.
module tb_shift_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_in, req1_in;
    logic [4:0]  req0_amt, req1_amt;
    logic        req0_op, req1_op;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic        res_id;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        logic        id;
    } exp_t;

    shift_arbiter dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_in    (req0_in),
        .req0_amt   (req0_amt),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_in    (req1_in),
        .req1_amt   (req1_amt),
        .req1_op    (req1_op),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id)
    );

    always #5 clock = ~clock;

    // Shift reference built from multiplication and masks.
    function automatic logic [31:0] ref_shift(input logic [31:0] x, input int amt, input bit arith);
        logic [63:0] wide;
        logic [31:0] mask;
        logic [31:0] r;
        if (!arith) begin
            wide = {32'd0, x};
            wide = wide * (64'd1 << amt);
            r = wide[31:0];
        end else begin
            mask = 32'hFFFF_FFFF >> amt;
            r = x >> amt;
            if (x[31]) r = r | ~mask;
        end
        return r;
    endfunction

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_in = '0; req1_in = '0;
        req0_amt = '0; req1_amt = '0;
        req0_op = 0; req1_op = 0;
        res_ready = 1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 0;
        idle_inputs();
        repeat (2) @(negedge clock);
        reset_n = 1;
    endtask

    // Issues one op on a port and returns the result and accept-to-visible latency in edges.
    task automatic do_op(input bit port, input logic [31:0] x, input logic [4:0] amt, input bit op,
                         output logic [31:0] d, output logic id, output int lat);
        int wait_c;
        d = '0; id = 0; lat = -1;
        @(negedge clock);
        res_ready = 1;
        if (port == 0) begin req0_valid = 1; req0_in = x; req0_amt = amt; req0_op = op; end
        else           begin req1_valid = 1; req1_in = x; req1_amt = amt; req1_op = op; end
        wait_c = 0;
        #1;
        while (!(port ? req1_ready : req0_ready) && wait_c < 20) begin
            @(negedge clock); #1; wait_c++;
        end
        if (wait_c >= 20) begin
            req0_valid = 0; req1_valid = 0;
            return;
        end
        @(posedge clock);
        @(negedge clock);
        req0_valid = 0; req1_valid = 0;
        lat = 1;
        #1;
        while (!res_valid && lat < 20) begin
            @(posedge clock); lat++; @(negedge clock); #1;
        end
        d = res_data; id = res_id;
        @(posedge clock);
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle_inputs();
        req0_valid = 1; req1_valid = 1;
        #2;
        checks += 5;
        if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b expected 0", req0_ready); end
        if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b expected 0", req1_ready); end
        if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        if (res_data !== 32'h0) begin errors++; $display("FAIL reset_res_data: got %h expected 0", res_data); end
        if (res_id !== 1'b0) begin errors++; $display("FAIL reset_res_id: got %b expected 0", res_id); end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1;
        #1;
        checks += 2;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL first_tie_ready0: got %b expected 1", req0_ready); end
        if (req1_ready !== 1'b0) begin errors++; $display("FAIL first_tie_ready1: got %b expected 0", req1_ready); end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_basic_sll();
        logic [31:0] d; logic id; int lat;
        do_op(0, 32'h0000_0001, 5'd4, 0, d, id, lat);
        checks += 3;
        if (d !== 32'h0000_0010) begin errors++; $display("FAIL sll_data: got %h expected 00000010", d); end
        if (id !== 1'b0) begin errors++; $display("FAIL sll_id: got %b expected 0", id); end
        if (lat !== 2) begin errors++; $display("FAIL sll_latency: got %0d expected 2", lat); end
        @(negedge clock); #1;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL sll_back_to_idle: res_valid got %b expected 0", res_valid); end
    endtask

    task automatic test_shift_cases();
        logic [31:0] xs [5] = '{32'h8000_0000, 32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h0000_0003, 32'h8000_00F0};
        logic [4:0]  as [5] = '{5'd31, 5'd4, 5'd0, 5'd31, 5'd0};
        bit          os [5] = '{1, 1, 1, 0, 1};
        logic [31:0] es [5] = '{32'hFFFF_FFFF, 32'h07FF_FFFF, 32'h7FFF_FFF0, 32'h8000_0000, 32'h8000_00F0};
        logic [31:0] d; logic id; int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(1, xs[i], as[i], os[i], d, id, lat);
            checks += 2;
            if (d !== es[i]) begin errors++; $display("FAIL shift_case%0d_data: got %h expected %h", i, d, es[i]); end
            if (id !== 1'b1) begin errors++; $display("FAIL shift_case%0d_id: got %b expected 1", i, id); end
        end
    endtask

    task automatic test_fairness();
        exp_t q[$];
        exp_t e;
        bit e0, e1, erv;
        apply_reset();
        for (int c = 0; c < 17; c++) begin
            @(negedge clock);
            res_ready = 1;
            req0_valid = (c < 16); req1_valid = (c < 16);
            req0_in = $urandom; req0_amt = 5'($urandom_range(0, 31)); req0_op = 1'($urandom_range(0, 1));
            req1_in = $urandom; req1_amt = 5'($urandom_range(0, 31)); req1_op = 1'($urandom_range(0, 1));
            #1;
            e0  = (c < 16) && (c % 2 == 0) && ((c / 2) % 2 == 0);
            e1  = (c < 16) && (c % 2 == 0) && ((c / 2) % 2 == 1);
            erv = (c >= 2) && (c % 2 == 0);
            checks += 3;
            if (req0_ready !== e0) begin errors++; $display("FAIL fair_ready0 cyc%0d: got %b expected %b", c, req0_ready, e0); end
            if (req1_ready !== e1) begin errors++; $display("FAIL fair_ready1 cyc%0d: got %b expected %b", c, req1_ready, e1); end
            if (res_valid !== erv) begin errors++; $display("FAIL fair_res_valid cyc%0d: got %b expected %b", c, res_valid, erv); end
            if (erv) begin
                checks += 2;
                if (q.size() == 0) begin
                    errors++; $display("FAIL fair_queue cyc%0d: got empty expected entry", c);
                end else begin
                    e = q.pop_front();
                    if (res_data !== e.d) begin errors++; $display("FAIL fair_data cyc%0d: got %h expected %h", c, res_data, e.d); end
                    if (res_id !== e.id) begin errors++; $display("FAIL fair_id cyc%0d: got %b expected %b", c, res_id, e.id); end
                end
            end
            if (e0) q.push_back('{ref_shift(req0_in, int'(req0_amt), req0_op), 1'b0});
            if (e1) q.push_back('{ref_shift(req1_in, int'(req1_amt), req1_op), 1'b1});
        end
        req0_valid = 0; req1_valid = 0;
        @(negedge clock); #1;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL fair_drain: res_valid got %b expected 0", res_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_a, exp_b;
        exp_a = ref_shift(32'hDEAD_BEEF, 8, 0);
        exp_b = ref_shift(32'h8000_1234, 12, 1);
        @(negedge clock);
        req0_valid = 1; req0_in = 32'hDEAD_BEEF; req0_amt = 5'd8; req0_op = 0; res_ready = 0;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_a: ready0 got %b expected 1", req0_ready); end
        @(negedge clock);
        req0_in = 32'h8000_1234; req0_amt = 5'd12; req0_op = 1;
        #1;
        checks += 2;
        if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_exec_ready: got %b expected 0", req0_ready); end
        if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_exec_valid: got %b expected 0", res_valid); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); #1;
            checks += 4;
            if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d_valid: got %b expected 1", i, res_valid); end
            if (res_data !== exp_a) begin errors++; $display("FAIL bp_hold%0d_data: got %h expected %h", i, res_data, exp_a); end
            if (res_id !== 1'b0) begin errors++; $display("FAIL bp_hold%0d_id: got %b expected 0", i, res_id); end
            if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d_ready0: got %b expected 0", i, req0_ready); end
        end
        @(negedge clock);
        res_ready = 1;
        #1;
        checks += 2;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready0: got %b expected 1", req0_ready); end
        if (res_data !== exp_a) begin errors++; $display("FAIL bp_release_data: got %h expected %h", res_data, exp_a); end
        @(negedge clock);
        req0_valid = 0;
        #1;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_b_exec: res_valid got %b expected 0", res_valid); end
        @(negedge clock); #1;
        checks += 3;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_b_valid: got %b expected 1", res_valid); end
        if (res_data !== exp_b) begin errors++; $display("FAIL bp_b_data: got %h expected %h", res_data, exp_b); end
        if (res_id !== 1'b0) begin errors++; $display("FAIL bp_b_id: got %b expected 0", res_id); end
        @(negedge clock); #1;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_b_delivered: res_valid got %b expected 0", res_valid); end
    endtask

    task automatic test_async_reset();
        logic [31:0] exp_t0;
        @(negedge clock);
        req1_valid = 1; req1_in = 32'h1234_5678; req1_amt = 5'd3; req1_op = 0; res_ready = 1;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin errors++; $display("FAIL ar_accept: ready1 got %b expected 1", req1_ready); end
        @(posedge clock);
        #2;
        reset_n = 0; req1_valid = 0;
        #1;
        checks += 3;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL ar_exec_valid: got %b expected 0", res_valid); end
        if (req0_ready !== 1'b0) begin errors++; $display("FAIL ar_ready0: got %b expected 0", req0_ready); end
        if (req1_ready !== 1'b0) begin errors++; $display("FAIL ar_ready1: got %b expected 0", req1_ready); end
        @(posedge clock); #1;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL ar_held_valid: got %b expected 0", res_valid); end
        @(negedge clock);
        reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            checks++;
            if (res_valid !== 1'b0) begin errors++; $display("FAIL ar_no_result%0d: res_valid got %b expected 0", i, res_valid); end
        end
        // Reset while a result is pending must discard it at once.
        @(negedge clock);
        req0_valid = 1; req0_in = 32'h0000_00FF; req0_amt = 5'd1; req0_op = 0; res_ready = 0;
        @(negedge clock);
        req0_valid = 0;
        @(negedge clock); #1;
        checks++;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL ar_resp_valid: got %b expected 1", res_valid); end
        #1;
        reset_n = 0;
        #1;
        checks += 2;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL ar_resp_drop: res_valid got %b expected 0", res_valid); end
        if (res_data !== 32'h0) begin errors++; $display("FAIL ar_resp_data: got %h expected 0", res_data); end
        @(negedge clock);
        reset_n = 1;
        @(negedge clock);
        req0_valid = 1; req1_valid = 1; res_ready = 1;
        req0_in = 32'hF000_000F; req0_amt = 5'd4; req0_op = 1;
        req1_in = 32'h0000_0001; req1_amt = 5'd1; req1_op = 0;
        exp_t0 = ref_shift(32'hF000_000F, 4, 1);
        #1;
        checks += 2;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL ar_tie_ready0: got %b expected 1", req0_ready); end
        if (req1_ready !== 1'b0) begin errors++; $display("FAIL ar_tie_ready1: got %b expected 0", req1_ready); end
        @(negedge clock);
        req0_valid = 0; req1_valid = 0;
        @(negedge clock); #1;
        checks += 3;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL ar_tie_valid: got %b expected 1", res_valid); end
        if (res_id !== 1'b0) begin errors++; $display("FAIL ar_tie_id: got %b expected 0", res_id); end
        if (res_data !== exp_t0) begin errors++; $display("FAIL ar_tie_data: got %h expected %h", res_data, exp_t0); end
        @(negedge clock);
    endtask

    // Transaction model: at most one op in flight; a result waits until taken.
    task automatic test_random();
        bit          m_exec, m_resp, m_last, m_op, m_id, m_rid;
        logic [31:0] m_in, m_rd;
        int          m_amt;
        bit          v0, v1, window, have, g, e0, e1;
        int          ops, cyc;
        apply_reset();
        m_exec = 0; m_resp = 0; m_last = 1; m_op = 0; m_id = 0; m_rid = 0;
        m_in = '0; m_rd = '0; m_amt = 0;
        ops = 0; cyc = 0;
        while (ops < 10000 && cyc < 60000) begin
            @(negedge clock);
            cyc++;
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            req0_valid = v0; req1_valid = v1;
            req0_in = $urandom; req0_amt = 5'($urandom_range(0, 31)); req0_op = 1'($urandom_range(0, 1));
            req1_in = $urandom; req1_amt = 5'($urandom_range(0, 31)); req1_op = 1'($urandom_range(0, 1));
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            window = !m_exec && (!m_resp || res_ready);
            have   = v0 || v1;
            g      = (v0 && v1) ? !m_last : v1;
            e0     = window && have && !g;
            e1     = window && have && g;
            checks += 3;
            if (req0_ready !== e0) begin errors++; $display("FAIL rnd_ready0 cyc%0d: got %b expected %b", cyc, req0_ready, e0); end
            if (req1_ready !== e1) begin errors++; $display("FAIL rnd_ready1 cyc%0d: got %b expected %b", cyc, req1_ready, e1); end
            if (res_valid !== m_resp) begin errors++; $display("FAIL rnd_res_valid cyc%0d: got %b expected %b", cyc, res_valid, m_resp); end
            if (m_resp) begin
                checks += 2;
                if (res_data !== m_rd) begin errors++; $display("FAIL rnd_data cyc%0d: got %h expected %h", cyc, res_data, m_rd); end
                if (res_id !== m_rid) begin errors++; $display("FAIL rnd_id cyc%0d: got %b expected %b", cyc, res_id, m_rid); end
            end
            if (m_exec) begin
                m_rd   = ref_shift(m_in, m_amt, m_op);
                m_rid  = m_id;
                m_exec = 0;
                m_resp = 1;
            end else begin
                if (m_resp && res_ready) m_resp = 0;
                if (window && have) begin
                    m_in   = g ? req1_in : req0_in;
                    m_amt  = int'(g ? req1_amt : req0_amt);
                    m_op   = g ? req1_op : req0_op;
                    m_id   = g;
                    m_last = g;
                    m_exec = 1;
                    ops++;
                end
            end
        end
        checks++;
        if (ops < 10000) begin errors++; $display("FAIL rnd_budget: got %0d ops expected 10000", ops); end
        @(negedge clock);
        idle_inputs();
        repeat (3) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_basic_sll();
        test_shift_cases();
        test_fairness();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Two-port arbiter and sequencer for the shared 32-bit shift datapath (`sll_32` / `sra_32` barrel shifters). Two requesters, port 0 for ALU issue and port 1 for multdiv, present shift operations over valid/ready handshakes. The block grants one requester at a time with round-robin priority, registers the operands, drives them through the shifter, and returns the tagged result over a valid/ready result port with backpressure.

## Interface
- No parameters; datapath fixed at 32 bits, shift amount at 5 bits.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  requester k has an operation pending.
- `req0_ready`, `req1_ready`  out  1  handshake completes on a cycle where `reqk_valid && reqk_ready`.
- `req0_in`, `req1_in`  in  32  operand.
- `req0_amt`, `req1_amt`  in  5  shift amount, 0–31.
- `req0_op`, `req1_op`  in  1  0 = logical left (sll), 1 = arithmetic right (sra).
- `res_valid`  out  1  result register holds an undelivered result.
- `res_ready`  in  1  consumer accepts the result this cycle.
- `res_data`  out  32  shifted result.
- `res_id`  out  1  index of the requester that issued the result.

## Operation
- Internal registers:
  - `state` (IDLE, EXEC, RESP).
  - Operand register: `op_in`[31:0], `op_amt`[4:0], `op_sel`, `op_id`.
  - Result register: `res_data`, `res_id`.
  - Round-robin pointer `last` (1 bit, port most recently granted).
- Grant logic (combinational):
  - If only one `reqk_valid` is high, grant k.
  - If both are high, grant the port != `last`.
  - If neither is high, grant nothing.
  - `reqk_ready` = `accept_window && grant == k`.
  - `accept_window` = (state == IDLE) || (state == RESP && `res_ready`).
  - The ready of one port may depend on the other port's valid. Requesters must not make valid depend on ready.
- On a handshake:
  - Capture that port's in, amt, op and id into the operand register.
  - `last` <= granted id.
  - state -> EXEC.
  - `last` changes only on a completed handshake.
- EXEC (one cycle, no stall):
  - Result = `op_sel` ? sra(`op_in`, `op_amt`) : sll(`op_in`, `op_amt`).
  - Load `res_data` and `res_id` <= `op_id`.
  - state -> RESP.
  - `reqk_ready` is low in EXEC.
- RESP: `res_valid` is high. `res_data` and `res_id` stay stable until `res_ready`.
  - `res_ready` && new handshake same cycle: state -> EXEC (back-to-back).
  - `res_ready` && no request: state -> IDLE.
  - `!res_ready`: stay in RESP, hold everything.
- `res_valid` = (state == RESP).
- Shift rules:
  - sll fills with zeros.
  - sra replicates bit 31.
  - amt 0 passes the operand unchanged.
  - amt 31 with sra yields all copies of bit 31.
- State encoding 2'b11 is unreachable. If it is ever entered, the next state is IDLE.

## Timing
- Reset (`reset_n` low, asynchronous):
  - state = IDLE, `last` = 1 (so port 0 wins the first tie).
  - Operand and result registers = 0.
  - `res_valid` = 0, `res_data` = 0, `res_id` = 0.
  - `req0_ready` and `req1_ready` are 0 while reset is asserted.
  - Reset mid-operation drops any in-flight operation with no result delivered.
  - After release, both ready signals follow the grant logic in IDLE from the first cycle.
- Latency: handshake at edge N, EXEC during cycle N→N+1, `res_valid` high after edge N+1. Two cycles from accept to result visible.
- Throughput: one result per two cycles under continuous `res_ready`.
- Backpressure: `res_ready` low for M cycles extends RESP by M cycles. No request is accepted during that time.
- Fairness: with both ports continuously valid and `res_ready` high, grants alternate 0,1,0,1,… No port waits more than one other operation.

## Test plan
- Reset, then port 0 issues in=0x0000_0001, amt=4, op=sll with `res_ready`=1 → `res_valid` two cycles after accept with `res_data`=0x0000_0010, `res_id`=0. Block returns to IDLE.
- Port 1 issues in=0x8000_0000, amt=31, op=sra → `res_data`=0xFFFF_FFFF, `res_id`=1. Then in=0x7FFF_FFF0, amt=4, sra → 0x07FF_FFFF. Then amt=0 → operand unchanged.
- Both ports continuously valid right after reset, with `res_ready`=1 → grant order 0,1,0,1. A result on every second cycle. Each `res_id` matches its issuing port's operand.
- Result pending with `res_ready`=0 for 5 cycles while port 0 is valid → `res_data` and `res_id` stay stable, `req0_ready`=0. On the cycle `res_ready`=1, `req0_ready`=1 and the handshake completes. The next result follows one cycle later.
- Assert `reset_n` low asynchronously mid-cycle during EXEC → `res_valid` drops immediately and no result appears after release. Port 0 wins the first tie after release.
- Random-stimulus check against a reference shift model for 10k operations with random valids and `res_ready` → no lost, duplicated or reordered results per port.
